// File: rtl/onchip_mem_pixel_writer_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_pixel_writer_if
//  Bundles the 8-bit pixel stream (valid/ready with sop/eop framing) and the
//  single-port RAM write bus of the pixel writer.
//  master : the writer side. It consumes pixels and drives the RAM bus.
//  slave  : the environment side. It produces pixels and observes the RAM bus.
//  Signals:
//   pix_data/pix_valid/pix_sop/pix_eop   pixel stream towards the writer
//   pix_ready                            writer accepts the pixel this cycle
//   address/byteenable/chipselect/write/writedata/clken   RAM write port
// ---------------------------------------------------------------------------
interface onchip_mem_pixel_writer_if #(
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 8
);
   logic [PIX_W-1:0]   pix_data;
   logic               pix_valid;
   logic               pix_sop;
   logic               pix_eop;
   logic               pix_ready;
   logic [ADDR_W-1:0]  address;
   logic [3:0]         byteenable;
   logic               chipselect;
   logic               write;
   logic [4*PIX_W-1:0] writedata;
   logic               clken;

   modport master (
      input  pix_data, pix_valid, pix_sop, pix_eop,
      output pix_ready, address, byteenable, chipselect, write, writedata, clken
   );

   modport slave (
      output pix_data, pix_valid, pix_sop, pix_eop,
      input  pix_ready, address, byteenable, chipselect, write, writedata, clken
   );
endinterface

// File: rtl/onchip_mem_pixel_writer.sv
// ---------------------------------------------------------------------------
// onchip_mem_pixel_writer
//  Packs an 8-bit pixel stream four pixels per 32-bit word and writes the
//  words to consecutive addresses of a 4096x32 single-port RAM, starting at a
//  programmable base. A short final word is written with a partial byte mask.
//  Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             one-cycle pulse; latches base/limit (IDLE or DONE only)
//   i_base_addr         first RAM word address of the frame
//   i_max_words         word limit, 0 means 2**ADDR_W
//   bus (master)        pixel stream in, RAM write bus out
//   o_busy              frame in progress (FILL or DRAIN)
//   o_done              one-cycle frame completion pulse
//   o_overflow          sticky: word limit hit before end of frame
//   o_words_written     words written in the current frame
// ---------------------------------------------------------------------------
module onchip_mem_pixel_writer #(
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [ADDR_W-1:0]        i_base_addr,
   input  logic [ADDR_W:0]          i_max_words,
   onchip_mem_pixel_writer_if.master bus,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_overflow,
   output logic [ADDR_W:0]          o_words_written
);
   localparam int WORD_W = 4 * PIX_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_limit;
   logic [ADDR_W:0]     r_words;
   logic [1:0]          r_lane;
   logic [WORD_W-1:0]   r_pack;
   logic                r_sop_seen;
   logic                r_ready;
   logic                r_busy;
   logic                r_write;
   logic [3:0]          r_be;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_wdata;
   logic                r_done;
   logic                r_done_pend;
   logic                r_overflow;

   logic                w_start_ok;
   logic                w_take;
   logic [1:0]          w_k;
   logic [ADDR_W:0]     w_cnt_base;
   logic [ADDR_W:0]     w_cnt_next;
   logic [WORD_W-1:0]   w_pack_base;
   logic [WORD_W-1:0]   w_word;
   logic [3:0]          w_mask;
   logic                w_flush;
   logic                w_limit_hit;
   logic                w_drain_eop;

   assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Lane/word assembly for the pixel offered this cycle; sop restarts at lane 0, count 0
   always_comb begin
      w_take      = (r_state == S_FILL) && bus.pix_valid && (r_sop_seen || bus.pix_sop);
      w_drain_eop = (r_state == S_DRAIN) && bus.pix_valid && bus.pix_eop;
      if (bus.pix_sop) begin
         w_k         = 2'd0;
         w_cnt_base  = {(ADDR_W+1){1'b0}};
         w_pack_base = {WORD_W{1'b0}};
      end else begin
         w_k         = r_lane;
         w_cnt_base  = r_words;
         w_pack_base = r_pack;
      end
      w_cnt_next = w_cnt_base + {{ADDR_W{1'b0}}, 1'b1};
      w_word     = w_pack_base;
      case (w_k)
         2'd0: begin
            w_word[PIX_W-1:0] = bus.pix_data;
            w_mask            = 4'b0001;
         end
         2'd1: begin
            w_word[2*PIX_W-1:PIX_W] = bus.pix_data;
            w_mask                  = 4'b0011;
         end
         2'd2: begin
            w_word[3*PIX_W-1:2*PIX_W] = bus.pix_data;
            w_mask                    = 4'b0111;
         end
         default: begin
            w_word[4*PIX_W-1:3*PIX_W] = bus.pix_data;
            w_mask                    = 4'b1111;
         end
      endcase
      w_flush     = w_take && ((w_k == 2'd3) || bus.pix_eop);
      w_limit_hit = w_flush && (w_cnt_next == r_limit);
   end

   // Next-state decode; start is only honoured from IDLE or DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_FILL;
            else         w_next = S_IDLE;
         end
         S_FILL: begin
            if (w_flush && bus.pix_eop) w_next = S_DONE;
            else if (w_limit_hit)       w_next = S_DRAIN;
            else                        w_next = S_FILL;
         end
         S_DRAIN: begin
            if (w_drain_eop) w_next = S_DONE;
            else             w_next = S_DRAIN;
         end
         S_DONE: begin
            if (i_start) w_next = S_FILL;
            else         w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Datapath: packing, RAM write strobes, counters and status flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_base      <= {ADDR_W{1'b0}};
         r_limit     <= {(ADDR_W+1){1'b0}};
         r_words     <= {(ADDR_W+1){1'b0}};
         r_lane      <= 2'd0;
         r_pack      <= {WORD_W{1'b0}};
         r_sop_seen  <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_write     <= 1'b0;
         r_be        <= 4'b0000;
         r_addr      <= {ADDR_W{1'b0}};
         r_wdata     <= {WORD_W{1'b0}};
         r_done      <= 1'b0;
         r_done_pend <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_write     <= 1'b0;
         r_be        <= 4'b0000;
         // done for a FILL-terminated frame trails its final write by one cycle
         r_done      <= r_done_pend;
         r_done_pend <= 1'b0;
         r_ready     <= (w_next == S_FILL) || (w_next == S_DRAIN);
         r_busy      <= (w_next == S_FILL) || (w_next == S_DRAIN);
         if (w_start_ok) begin
            r_base     <= i_base_addr;
            r_limit    <= (i_max_words == {(ADDR_W+1){1'b0}}) ?
                          {1'b1, {ADDR_W{1'b0}}} : i_max_words;
            r_overflow <= 1'b0;
            r_words    <= {(ADDR_W+1){1'b0}};
            r_lane     <= 2'd0;
            r_pack     <= {WORD_W{1'b0}};
            r_sop_seen <= 1'b0;
         end else if (w_take) begin
            r_sop_seen <= 1'b1;
            if (w_flush) begin
               // address wraps naturally in ADDR_W bits
               r_write <= 1'b1;
               r_addr  <= r_base + w_cnt_base[ADDR_W-1:0];
               r_wdata <= w_word;
               r_be    <= w_mask;
               r_words <= w_cnt_next;
               r_lane  <= 2'd0;
               r_pack  <= {WORD_W{1'b0}};
               if (bus.pix_eop)      r_done_pend <= 1'b1;
               else if (w_limit_hit) r_overflow  <= 1'b1;
            end else begin
               r_lane  <= w_k + 2'd1;
               r_pack  <= w_word;
               r_words <= w_cnt_base;
            end
         end else if (w_drain_eop) begin
            r_done <= 1'b1;
         end
      end
   end

   assign bus.pix_ready  = r_ready;
   assign bus.address    = r_addr;
   assign bus.byteenable = r_be;
   assign bus.chipselect = r_write;
   assign bus.write      = r_write;
   assign bus.writedata  = r_wdata;
   assign bus.clken      = 1'b1;

   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_overflow      = r_overflow;
   assign o_words_written = r_words;
endmodule
